// File: rtl/alu_share_arbiter.sv
// Two-requester front end for the shared ALU. A granted op's result appears in its response slot one cycle later.
// A slot that is full and not being drained blocks further grants to its requester.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter bit RR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic [3:0]       rsp0_flags,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic [3:0]       rsp1_flags,
   output logic             rsp1_err,
   output logic [7:0]       busy_cnt
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

   slot_e            slot0_q, slot0_d, slot1_q, slot1_d;
   logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
   logic [3:0]       flg0_q, flg0_d, flg1_q, flg1_d;
   logic             err0_q, err0_d, err1_q, err1_d;
   logic             last_q, last_d;
   logic [7:0]       busy_q, busy_d;

   logic             elig0, elig1, gnt0, gnt1, sel_legal;
   logic [3:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b, cap_res;
   logic [3:0]       cap_flags;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b1001, 4'b0111, 4'b0110, 4'b0100,
         4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011: op_legal = 1'b1;
         default:                                      op_legal = 1'b0;
      endcase
   endfunction

   always_comb begin : arb
      // A full slot being drained this cycle can be refilled in the same cycle.
      elig0 = !rst && req0_valid && (slot0_q == EMPTY || rsp0_ready);
      elig1 = !rst && req1_valid && (slot1_q == EMPTY || rsp1_ready);
      // last_q=1 means req1 won last time, so req0 wins a tie.
      gnt0  = elig0 && (!elig1 || !RR_EN || last_q);
      gnt1  = elig1 && !gnt0;

      sel_op    = gnt1 ? req1_op : req0_op;
      sel_a     = gnt1 ? req1_a  : req0_a;
      sel_b     = gnt1 ? req1_b  : req0_b;
      sel_legal = op_legal(sel_op);

      alu_op = 4'b0000;
      alu_a  = '0;
      alu_b  = '0;
      if ((gnt0 || gnt1) && sel_legal) begin
         alu_op = sel_op;
         alu_a  = sel_a;
         alu_b  = sel_b;
      end

      cap_res   = sel_legal ? alu_result : '0;
      cap_flags = sel_legal ? alu_flags  : 4'b1000;
   end

   always_comb begin : nxt
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      flg0_d  = flg0_q;
      flg1_d  = flg1_q;
      err0_d  = err0_q;
      err1_d  = err1_q;
      last_d  = last_q;
      busy_d  = busy_q;

      case (slot0_q)
         EMPTY:   if (gnt0) slot0_d = FULL;
         FULL:    if (!gnt0 && rsp0_ready) slot0_d = EMPTY;
         default: slot0_d = EMPTY;
      endcase
      case (slot1_q)
         EMPTY:   if (gnt1) slot1_d = FULL;
         FULL:    if (!gnt1 && rsp1_ready) slot1_d = EMPTY;
         default: slot1_d = EMPTY;
      endcase

      if (gnt0) begin
         res0_d = cap_res;
         flg0_d = cap_flags;
         err0_d = !sel_legal;
         last_d = 1'b0;
      end
      if (gnt1) begin
         res1_d = cap_res;
         flg1_d = cap_flags;
         err1_d = !sel_legal;
         last_d = 1'b1;
      end

      if (((req0_valid && !gnt0) || (req1_valid && !gnt1)) && busy_q != 8'hFF)
         busy_d = busy_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q <= EMPTY;
         slot1_q <= EMPTY;
         res0_q  <= '0;
         res1_q  <= '0;
         flg0_q  <= 4'b0000;
         flg1_q  <= 4'b0000;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         last_q  <= 1'b1;
         busy_q  <= 8'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
         flg0_q  <= flg0_d;
         flg1_q  <= flg1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign rsp0_valid  = (slot0_q == FULL);
   assign rsp1_valid  = (slot1_q == FULL);
   assign rsp0_result = res0_q;
   assign rsp1_result = res1_q;
   assign rsp0_flags  = flg0_q;
   assign rsp1_flags  = flg1_q;
   assign rsp0_err    = err0_q;
   assign rsp1_err    = err1_q;
   assign busy_cnt    = busy_q;
endmodule
